band_energy_scanner: RTL and testbench

Downstream consumer of the wavelet filter bank. Each sample period it captures the signed outputs of all NUM_FILTERS FIR stages and updates one leaky-integrated energy accumulator per band, scanning one band per clock. It then presents the index and energy of the strongest band on a valid/ready interface for the readout logic.

---
 rtl/wavelet_pkg.sv | 21 ++
 rtl/band_leaky_update.sv | 37 +++
 rtl/band_energy_scanner.sv | 164 ++++++++++++++++
 tb/tb_band_energy_scanner.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared definitions for the wavelet filter bank and its downstream consumers.
package wavelet_pkg;

    // Control states of the band energy scanner.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } scan_state_e;

    // Default datapath widths and leak factor shared across the filter bank.
    localparam int DEFAULT_SUM_WIDTH   = 12;
    localparam int DEFAULT_ACC_WIDTH   = 16;
    localparam int DEFAULT_DECAY_SHIFT = 3;

    // Number of bits needed to index num_bands bands (at least one bit).
    function automatic int band_idx_width(input int num_bands);
        return (num_bands < 2) ? 1 : $clog2(num_bands);
    endfunction

endpackage

// File: rtl/band_leaky_update.sv
// Single-band energy update: magnitude of a signed FIR output, leak of the old
// accumulator and saturating add. Purely combinational, time-shared by the scanner.
module band_leaky_update
    import wavelet_pkg::*;
#(
    parameter int SUM_WIDTH   = DEFAULT_SUM_WIDTH,
    parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
    parameter int DECAY_SHIFT = DEFAULT_DECAY_SHIFT
) (
    input  logic signed [SUM_WIDTH-1:0] sum,
    input  logic        [ACC_WIDTH-1:0] acc_in,
    output logic        [ACC_WIDTH-1:0] acc_out
);

    logic [SUM_WIDTH-1:0] sum_bits;
    logic [SUM_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] leaked;
    logic [ACC_WIDTH:0]   total;

    assign sum_bits = sum;

    // Magnitude, leak and saturating accumulate; the most negative input
    // becomes 2^(SUM_WIDTH-1) because the negation is read back as unsigned.
    always_comb begin
        mag     = sum_bits;
        leaked  = '0;
        total   = '0;
        acc_out = '0;
        if (sum_bits[SUM_WIDTH-1]) begin
            mag = ~sum_bits + SUM_WIDTH'(1);
        end
        leaked  = acc_in - (acc_in >> DECAY_SHIFT);
        total   = (ACC_WIDTH+1)'(leaked) + (ACC_WIDTH+1)'(mag);
        acc_out = total[ACC_WIDTH] ? '1 : total[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/band_energy_scanner.sv
// Captures one filter-bank result per strobe, updates one leaky energy
// accumulator per clock and presents the strongest band on a valid/ready port.
module band_energy_scanner
    import wavelet_pkg::*;
#(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_FILTERS   = 8,
    parameter int SUM_WIDTH     = DEFAULT_SUM_WIDTH,
    parameter int ACC_WIDTH     = DEFAULT_ACC_WIDTH,
    parameter int DECAY_SHIFT   = DEFAULT_DECAY_SHIFT
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    i_sample_valid,
    input  logic [NUM_FILTERS*SUM_WIDTH-1:0]        i_fir_sums,
    output logic                                    o_band_valid,
    input  logic                                    i_band_ready,
    output logic [band_idx_width(NUM_FILTERS)-1:0]  o_band_idx,
    output logic [ACC_WIDTH-1:0]                    o_band_energy,
    output logic                                    o_overrun
);

    localparam int IDX_W = band_idx_width(NUM_FILTERS);

    if (BITS_PER_ELEM < 1 || NUM_FILTERS < 2 || ACC_WIDTH < SUM_WIDTH + 1 ||
        DECAY_SHIFT < 1 || DECAY_SHIFT > ACC_WIDTH - 1) begin : g_param_check
        $error("band_energy_scanner: illegal parameter combination");
    end

    scan_state_e state;
    scan_state_e next_state;

    logic [NUM_FILTERS*SUM_WIDTH-1:0] cap_buf;
    logic [IDX_W-1:0]                 scan_cnt;
    logic [ACC_WIDTH-1:0]             acc_mem [NUM_FILTERS];
    logic [ACC_WIDTH-1:0]             acc_new;
    logic [ACC_WIDTH-1:0]             max_val;
    logic [IDX_W-1:0]                 max_idx;
    logic [ACC_WIDTH-1:0]             win_val;
    logic [IDX_W-1:0]                 win_idx;
    logic signed [SUM_WIDTH-1:0]      cur_sum;

    logic handshake;
    logic capture;
    logic scan_en;
    logic last_band;
    logic drop;

    assign handshake = o_band_valid && i_band_ready;
    assign last_band = (scan_cnt == IDX_W'(NUM_FILTERS - 1));
    assign cur_sum   = cap_buf[int'(scan_cnt)*SUM_WIDTH +: SUM_WIDTH];

    band_leaky_update #(
        .SUM_WIDTH   (SUM_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_update (
        .sum     (cur_sum),
        .acc_in  (acc_mem[scan_cnt]),
        .acc_out (acc_new)
    );

    // Running maximum including the band being updated this cycle; band 0
    // always wins and later bands must be strictly larger to take over.
    always_comb begin
        win_val = max_val;
        win_idx = max_idx;
        if (scan_cnt == '0 || acc_new > max_val) begin
            win_val = acc_new;
            win_idx = scan_cnt;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus capture/scan/drop decisions for the current cycle.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        scan_en    = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (i_sample_valid) begin
                    capture    = 1'b1;
                    next_state = SCAN;
                end
            end
            SCAN: begin
                scan_en = 1'b1;
                drop    = i_sample_valid;
                if (last_band) begin
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    if (i_sample_valid) begin
                        capture    = 1'b1;
                        next_state = SCAN;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    drop = i_sample_valid;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture buffer, scan counter, accumulator array and running maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_buf  <= '0;
            scan_cnt <= '0;
            max_val  <= '0;
            max_idx  <= '0;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                acc_mem[k] <= '0;
            end
        end else if (capture) begin
            cap_buf  <= i_fir_sums;
            scan_cnt <= '0;
            max_val  <= '0;
            max_idx  <= '0;
        end else if (scan_en) begin
            acc_mem[scan_cnt] <= acc_new;
            scan_cnt          <= scan_cnt + IDX_W'(1);
            max_val           <= win_val;
            max_idx           <= win_idx;
        end
    end

    // Registered result port and overrun pulse; the result loads on the last
    // band and holds until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_band_valid  <= 1'b0;
            o_band_idx    <= '0;
            o_band_energy <= '0;
            o_overrun     <= 1'b0;
        end else begin
            o_overrun <= drop;
            if (scan_en && last_band) begin
                o_band_valid  <= 1'b1;
                o_band_idx    <= win_idx;
                o_band_energy <= win_val;
            end else if (handshake) begin
                o_band_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_band_energy_scanner.sv
// Directed scoreboard bench for band_energy_scanner (default and 13-bit accumulator instances).
module tb_band_energy_scanner;

    localparam int NF = 8;
    localparam int SW = 12;

    typedef struct {
        int idx;
        int energy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic               i_sample_valid;
    logic [NF*SW-1:0]   i_fir_sums;
    logic               i_band_ready;
    logic               o_band_valid;
    logic [2:0]         o_band_idx;
    logic [15:0]        o_band_energy;
    logic               o_overrun;

    logic               s2_valid;
    logic [NF*SW-1:0]   s2_sums;
    logic               s2_ready;
    logic               v2;
    logic [2:0]         idx2;
    logic [12:0]        e2;
    logic               ovr2;

    exp_t sb_q[$];
    int   acc_m[NF];
    int   vectors = 0;
    int   miscompares = 0;

    band_energy_scanner dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample_valid (i_sample_valid),
        .i_fir_sums     (i_fir_sums),
        .o_band_valid   (o_band_valid),
        .i_band_ready   (i_band_ready),
        .o_band_idx     (o_band_idx),
        .o_band_energy  (o_band_energy),
        .o_overrun      (o_overrun)
    );

    band_energy_scanner #(.ACC_WIDTH(13)) dut13 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample_valid (s2_valid),
        .i_fir_sums     (s2_sums),
        .o_band_valid   (v2),
        .i_band_ready   (s2_ready),
        .o_band_idx     (idx2),
        .o_band_energy  (e2),
        .o_overrun      (ovr2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NF*SW-1:0] put_band(input logic [NF*SW-1:0] base, input int band, input int val);
        logic [NF*SW-1:0] r;
        logic [31:0]      v;
        r = base;
        v = val;
        r[band*SW +: SW] = v[SW-1:0];
        return r;
    endfunction

    // Reference model: integer leaky integration with 16-bit saturation.
    task automatic model_step(input logic [NF*SW-1:0] sums, output exp_t r);
        logic signed [SW-1:0] s;
        int v;
        int mag;
        int a;
        int best;
        best = 0;
        r.idx = 0;
        r.energy = 0;
        for (int k = 0; k < NF; k++) begin
            s = sums[k*SW +: SW];
            v = s;
            mag = (v < 0) ? -v : v;
            a = acc_m[k] - (acc_m[k] >> 3) + mag;
            if (a > 65535) a = 65535;
            acc_m[k] = a;
            if (k == 0 || a > best) begin
                best = a;
                r.idx = k;
                r.energy = a;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NF*SW-1:0] sums, input bit ready);
        exp_t r;
        @(negedge clk);
        i_fir_sums     = sums;
        i_sample_valid = 1'b1;
        i_band_ready   = ready;
        @(posedge clk);
        model_step(sums, r);
        sb_q.push_back(r);
        #1 i_sample_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input bit ready_high);
        exp_t e;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j == 8) begin
                checkOutput({tag, "_valid_rise"}, o_band_valid, 1);
            end else if (j == 0 || j == 7) begin
                checkOutput({tag, "_valid_early"}, o_band_valid, 0);
                checkOutput({tag, "_no_overrun"}, o_overrun, 0);
            end
        end
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            checkOutput({tag, "_idx"}, o_band_idx, e.idx);
            checkOutput({tag, "_energy"}, o_band_energy, e.energy);
        end
        if (ready_high) begin
            @(negedge clk);
            checkOutput({tag, "_valid_drop"}, o_band_valid, 0);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < NF; k++) acc_m[k] = 0;
        sb_q.delete();
        @(negedge clk);
        checkOutput("reset_mid_valid", o_band_valid, 0);
        checkOutput("reset_mid_energy", o_band_energy, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int a2;
        int prev;

        i_sample_valid = 1'b0;
        i_fir_sums     = '0;
        i_band_ready   = 1'b0;
        s2_valid       = 1'b0;
        s2_sums        = '0;
        s2_ready       = 1'b0;
        for (int k = 0; k < NF; k++) acc_m[k] = 0;

        // Reset held while inputs toggle randomly.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_sample_valid = 1'($urandom_range(0, 1));
            i_fir_sums     = {$urandom, $urandom, $urandom};
            i_band_ready   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        checkOutput("reset_valid", o_band_valid, 0);
        checkOutput("reset_idx", o_band_idx, 0);
        checkOutput("reset_energy", o_band_energy, 0);
        checkOutput("reset_overrun", o_overrun, 0);
        checkOutput("reset_valid13", v2, 0);
        i_sample_valid = 1'b0;
        i_fir_sums     = '0;
        i_band_ready   = 1'b1;
        rst_n          = 1'b1;

        applyStimulus('0, 1'b1);
        waitResult("zeros", 1'b1);

        applyStimulus(put_band('0, 2, 100), 1'b1);
        waitResult("band2_100", 1'b1);

        applyStimulus('0, 1'b1);
        waitResult("band2_decay", 1'b1);

        applyStimulus(put_band('0, 5, -2048), 1'b1);
        waitResult("band5_most_neg", 1'b1);

        doReset();
        applyStimulus(put_band(put_band('0, 1, 50), 6, 50), 1'b1);
        waitResult("tie_lower", 1'b1);

        // Overrun: ready low, second strobe while scanning.
        applyStimulus(put_band('0, 3, 300), 1'b0);
        repeat (4) @(negedge clk);
        i_fir_sums     = put_band('0, 4, 999);
        i_sample_valid = 1'b1;
        @(posedge clk);
        #1 i_sample_valid = 1'b0;
        @(negedge clk);
        checkOutput("scan_drop_overrun", o_overrun, 1);
        checkOutput("scan_drop_valid", o_band_valid, 0);
        @(negedge clk);
        checkOutput("scan_drop_pulse_end", o_overrun, 0);
        repeat (3) @(negedge clk);
        checkOutput("held_valid_rise", o_band_valid, 1);
        e = sb_q.pop_front();
        checkOutput("held_idx", o_band_idx, e.idx);
        checkOutput("held_energy", o_band_energy, e.energy);
        repeat (2) @(negedge clk);
        checkOutput("held_valid_stable", o_band_valid, 1);
        checkOutput("held_idx_stable", o_band_idx, e.idx);
        checkOutput("held_energy_stable", o_band_energy, e.energy);

        // Strobe while presenting without a handshake is dropped too.
        i_sample_valid = 1'b1;
        @(posedge clk);
        #1 i_sample_valid = 1'b0;
        @(negedge clk);
        checkOutput("present_drop_overrun", o_overrun, 1);
        checkOutput("present_drop_valid", o_band_valid, 1);
        checkOutput("present_drop_energy", o_band_energy, e.energy);

        // Handshake and new strobe in the same cycle.
        applyStimulus(put_band('0, 7, 400), 1'b1);
        waitResult("same_cycle", 1'b1);

        // 13-bit accumulator instance driven toward saturation.
        a2 = 0;
        prev = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            s2_sums  = put_band('0, 0, 2047);
            s2_valid = 1'b1;
            s2_ready = 1'b1;
            @(posedge clk);
            a2 = a2 - (a2 >> 3) + 2047;
            if (a2 > 8191) a2 = 8191;
            #1 s2_valid = 1'b0;
            repeat (9) @(negedge clk);
            checkOutput("acc13_valid", v2, 1);
            checkOutput("acc13_idx", idx2, 0);
            checkOutput("acc13_energy", e2, a2);
            checkOutput("acc13_monotone", 32'(e2 >= 13'(prev)), 1);
            prev = e2;
        end
        checkOutput("acc13_clamp", e2, 8191);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
